sarlock_key_loader: RTL

//  Upstream key-delivery stage for the SAR-locked circuit: receives the key serially from secure
//  key storage over a valid/ready bit stream, assembles it into a shadow register and commits it
//  to the parallel key port of the locked wrapper. key_out stays all-zero until a complete,

---
 rtl/sarlock_pkg.sv | 25 ++
 rtl/sarlock_key_loader_if.sv | 26 ++
 rtl/sarlock_key_shreg.sv | 38 +++
 rtl/sarlock_key_loader.sv | 139 +++++++++++++
 4 files changed

// File: rtl/sarlock_pkg.sv
// Shared types and constants for the SAR-lock key delivery path.
// Consumers: sarlock_key_loader_if, sarlock_key_shreg, sarlock_key_loader.
package sarlock_pkg;

  // Default key width; must equal the locked wrapper's key width.
  localparam int KEY_W_DEFAULT = 8;

  // Value presented on the key port whenever no checked key is committed.
  localparam logic [KEY_W_DEFAULT-1:0] KEY_RST = '0;

  // PARITY and ERROR are only reachable with KEY_PARITY_CHECK_EN defined.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_PARITY = 3'd2,
    ST_LOADED = 3'd3,
    ST_ERROR  = 3'd4
  } state_e;

  // Bit-counter width able to hold the value key_w itself.
  function automatic int cnt_width(input int key_w);
    return $clog2(key_w + 1);
  endfunction

endpackage

// File: rtl/sarlock_key_loader_if.sv
// Serial key stream plus committed-key port between key storage, the loader and the locked wrapper.
// master = key storage side (drives the stream), slave = the loader.
interface sarlock_key_loader_if #(
  parameter int KEY_W = sarlock_pkg::KEY_W_DEFAULT
) ();

  logic             load_start;
  logic             ser_valid;
  logic             ser_data;
  logic             ser_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             err;

  modport master (
    output load_start, ser_valid, ser_data,
    input  ser_ready, key_out, key_valid, busy, err
  );

  modport slave (
    input  load_start, ser_valid, ser_data,
    output ser_ready, key_out, key_valid, busy, err
  );

endinterface

// File: rtl/sarlock_key_shreg.sv
// Shadow shift register and accepted-bit counter for the key loader.
// Shifts MSB first; the counter saturates at KEY_W so it can never wrap.
module sarlock_key_shreg
  import sarlock_pkg::*;
#(
  parameter  int KEY_W = KEY_W_DEFAULT,
  localparam int CNT_W = cnt_width(KEY_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift,
  input  logic             bit_in,
  output logic [KEY_W-1:0] shadow,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             parity
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking assignments here would create order-dependent simulation/synthesis mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= KEY_W'(KEY_RST);
      count  <= '0;
    end else if (clr) begin
      shadow <= KEY_W'(KEY_RST);
      count  <= '0;
    end else if (shift && !full) begin
      shadow <= {shadow[KEY_W-2:0], bit_in};
      count  <= count + CNT_W'(1);
    end
  end

  assign full   = (count == CNT_W'(KEY_W));
  assign parity = ^shadow;

endmodule

// File: rtl/sarlock_key_loader.sv
// Serial-to-parallel key loader: assembles a key from a valid/ready bit stream and commits it
// whole. Define KEY_PARITY_CHECK_EN to require a trailing even-parity bit (mismatch -> ERROR).
module sarlock_key_loader
  import sarlock_pkg::*;
#(
  parameter  int KEY_W = KEY_W_DEFAULT,
  localparam int CNT_W = cnt_width(KEY_W)
) (
  input logic                  clk,
  input logic                  rst_n,
  sarlock_key_loader_if.slave  kl
);

  state_e           state;
  logic             ready_q;
  logic             busy_q;
  logic             key_valid_q;
  logic [KEY_W-1:0] key_q;

  logic [KEY_W-1:0] shadow;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             parity;

  logic xfer;
  logic last_bit;
  logic shift_en;

  // A bit is only consumed on a real handshake; load_start wins over a simultaneous bit.
  assign xfer     = kl.ser_valid && ready_q;
  assign last_bit = (count == CNT_W'(KEY_W - 1));
  assign shift_en = xfer && (state == ST_SHIFT) && !kl.load_start;

  sarlock_key_shreg #(.KEY_W(KEY_W)) u_shreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (kl.load_start),
    .shift  (shift_en),
    .bit_in (kl.ser_data),
    .shadow (shadow),
    .count  (count),
    .full   (full),
    .parity (parity)
  );

`ifdef KEY_PARITY_CHECK_EN
  logic err_q;

  // NOTE: every flop, including the key register, has an async reset so the locked circuit
  // sees an all-zero key the instant rst_n falls, not one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      key_q       <= KEY_W'(KEY_RST);
      err_q       <= 1'b0;
    end else if (kl.load_start) begin
      state       <= ST_SHIFT;
      ready_q     <= 1'b1;
      busy_q      <= 1'b1;
      key_valid_q <= 1'b0;
      key_q       <= KEY_W'(KEY_RST);
      err_q       <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          if (xfer && last_bit) state <= ST_PARITY;
        end
        ST_PARITY: begin
          if (xfer) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            // Even parity over key plus trailing bit: the bit must equal the key's XOR.
            if (full && (kl.ser_data == parity)) begin
              state       <= ST_LOADED;
              key_q       <= shadow;
              key_valid_q <= 1'b1;
            end else begin
              state       <= ST_ERROR;
              key_q       <= KEY_W'(KEY_RST);
              key_valid_q <= 1'b0;
              err_q       <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign kl.err = err_q;
`else
  logic [KEY_W-1:0] shift_next;
  logic             unused_parity_path;

  assign shift_next         = {shadow[KEY_W-2:0], kl.ser_data};
  assign unused_parity_path = full ^ parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      key_valid_q <= 1'b0;
      key_q       <= KEY_W'(KEY_RST);
    end else if (kl.load_start) begin
      state       <= ST_SHIFT;
      ready_q     <= 1'b1;
      busy_q      <= 1'b1;
      key_valid_q <= 1'b0;
      key_q       <= KEY_W'(KEY_RST);
    end else begin
      case (state)
        ST_SHIFT: begin
          // Commit includes the bit arriving this cycle, so key_valid rises one cycle later.
          if (xfer && last_bit) begin
            state       <= ST_LOADED;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            key_q       <= shift_next;
            key_valid_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign kl.err = 1'b0;
`endif

  assign kl.ser_ready = ready_q;
  assign kl.busy      = busy_q;
  assign kl.key_valid = key_valid_q;
  assign kl.key_out   = key_q;

endmodule
